// File: rtl/fft_bus_loader_if.sv
// Sample stream, openMSP430-style peripheral bus and result stream used by fft_bus_loader.
// master = loader side, slave = environment (sample source, FFT peripheral, result sink).
interface fft_bus_loader_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_ready;

    modport master (
        input  s_data, s_valid, per_dout, r_ready,
        output s_ready, per_addr, per_din, per_en, per_we, r_data, r_valid
    );

    modport slave (
        output s_data, s_valid, per_dout, r_ready,
        input  s_ready, per_addr, per_din, per_en, per_we, r_data, r_valid
    );
endinterface

// File: rtl/fft_bus_loader.sv
// Host-side bus initiator: pushes a frame of samples into the FFT peripheral, then reads back results.
// Optional frame-complete interrupt enabled by defining FFT_BUS_LOADER_IRQ_EN.
module fft_bus_loader #(
    parameter int          NSAMP   = 16,
    parameter int          NREAD   = 3,
    parameter logic [13:0] WR_ADDR = 14'h098,
    parameter logic [13:0] RD_BASE = 14'h088,
    parameter int          CNT_W   = 5
) (
    input  logic             mclk,
    input  logic             puc_rst_n,
    input  logic             start,
    input  logic             irq_clr,
    fft_bus_loader_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    typedef enum logic [2:0] {IDLE, LOAD, RD_ISSUE, RD_WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] NSAMP_C = CNT_W'(NSAMP);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(NREAD - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_nx;
    logic [CNT_W-1:0]  rd_idx, rd_idx_nx;
    logic              per_en_q, per_en_nx;
    logic [1:0]        per_we_q, per_we_nx;
    logic [13:0]       per_addr_q, per_addr_nx;
    logic [15:0]       per_din_q, per_din_nx;
    logic [15:0]       r_data_q, r_data_nx;
    logic              r_valid_q, r_valid_nx;
    logic              irq_q, irq_nx;
    logic              s_ready_c;

    assign s_ready_c = (state == LOAD) && (wr_cnt < NSAMP_C);

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_idx     <= '0;
            per_en_q   <= 1'b0;
            per_we_q   <= 2'b00;
            per_addr_q <= '0;
            per_din_q  <= '0;
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_cnt     <= wr_cnt_nx;
            rd_idx     <= rd_idx_nx;
            per_en_q   <= per_en_nx;
            per_we_q   <= per_we_nx;
            per_addr_q <= per_addr_nx;
            per_din_q  <= per_din_nx;
            r_data_q   <= r_data_nx;
            r_valid_q  <= r_valid_nx;
            irq_q      <= irq_nx;
        end
    end

    // Bus registers default to an idle (all-zero) cycle so every transfer lasts one clock.
    always_comb begin
        state_nx    = state;
        wr_cnt_nx   = wr_cnt;
        rd_idx_nx   = rd_idx;
        per_en_nx   = 1'b0;
        per_we_nx   = 2'b00;
        per_addr_nx = '0;
        per_din_nx  = '0;
        r_data_nx   = r_data_q;
        r_valid_nx  = r_valid_q;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = LOAD;
                    wr_cnt_nx = '0;
                    rd_idx_nx = '0;
                end
            end
            LOAD: begin
                if (wr_cnt == NSAMP_C) begin
                    // The last write cycle is on the bus now; the first read follows it directly.
                    per_en_nx   = 1'b1;
                    per_addr_nx = RD_BASE;
                    state_nx    = RD_ISSUE;
                end else if (bus.s_valid && s_ready_c) begin
                    wr_cnt_nx   = wr_cnt + 1'b1;
                    per_en_nx   = 1'b1;
                    per_we_nx   = 2'b11;
                    per_addr_nx = WR_ADDR;
                    per_din_nx  = bus.s_data;
                end
            end
            RD_ISSUE: begin
                r_data_nx  = bus.per_dout;
                r_valid_nx = 1'b1;
                state_nx   = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.r_ready) begin
                    r_valid_nx = 1'b0;
                    if (rd_idx == RD_LAST) begin
                        state_nx = DONE;
                    end else begin
                        rd_idx_nx   = rd_idx + 1'b1;
                        per_en_nx   = 1'b1;
                        per_addr_nx = RD_BASE + {{(14-CNT_W){1'b0}}, rd_idx} + 14'd1;
                        state_nx    = RD_ISSUE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef FFT_BUS_LOADER_IRQ_EN
    // A completing frame takes priority over a simultaneous clear.
    always_comb begin
        irq_nx = irq_q;
        if (state == DONE)
            irq_nx = 1'b1;
        else if (irq_clr)
            irq_nx = 1'b0;
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq_nx         = 1'b0;
`endif

    assign bus.s_ready  = s_ready_c;
    assign bus.per_en   = per_en_q;
    assign bus.per_we   = per_we_q;
    assign bus.per_addr = per_addr_q;
    assign bus.per_din  = per_din_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_valid  = r_valid_q;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign irq          = irq_q;

endmodule

// File: tb/tb_fft_bus_loader.sv
// Directed bench for fft_bus_loader with a shift-register model of the FFT sample peripheral.
module tb_fft_bus_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic irq_clr;
    logic busy, done, irq;

    fft_bus_loader_if bus ();

    fft_bus_loader dut (
        .mclk      (clk),
        .puc_rst_n (rst_n),
        .start     (start),
        .irq_clr   (irq_clr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Responder: each write shifts in a sample; result word k is the k-th most recent sample.
    logic [15:0] sr [16];
    logic [13:0] off;
    always @(posedge clk) begin
        if (bus.per_en && bus.per_we == 2'b11) begin
            for (int i = 15; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= bus.per_din;
        end
    end
    always_comb begin
        off          = bus.per_addr - 14'h088;
        bus.per_dout = 16'h0000;
        if (bus.per_en && bus.per_we == 2'b00 && off < 14'd16)
            bus.per_dout = sr[off[3:0]];
    end

    // Bus / stream activity log
    int          cyc = 0;
    logic [15:0] wr_din [$];
    logic [13:0] rd_addr [$];
    logic [15:0] res [$];
    int          first_wr, last_wr, first_rd;
    int          wr_bad_addr, idle_bad, done_cnt;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.per_en && bus.per_we == 2'b11) begin
            if (wr_din.size() == 0) first_wr = cyc;
            last_wr = cyc;
            wr_din.push_back(bus.per_din);
            if (bus.per_addr != 14'h098) wr_bad_addr++;
        end else if (bus.per_en) begin
            if (rd_addr.size() == 0) first_rd = cyc;
            rd_addr.push_back(bus.per_addr);
        end else if (bus.per_we != 2'b00 || bus.per_addr != 14'h0 || bus.per_din != 16'h0) begin
            idle_bad++;
        end
        if (bus.r_valid && bus.r_ready) res.push_back(bus.r_data);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_din.delete();
        rd_addr.delete();
        res.delete();
        first_wr = 0; last_wr = 0; first_rd = 0;
        wr_bad_addr = 0; idle_bad = 0; done_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int last, input bit gaps);
        int  idx = first;
        int  n   = 0;
        bit  hs;
        while (idx <= last && n < 200) begin
            bus.s_valid = gaps ? (n % 2 == 0) : 1'b1;
            bus.s_data  = 16'(idx);
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            tick();
            if (hs) idx++;
            n++;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = 16'h0;
        check("feed_complete", (idx > last), 1);
    endtask

    task automatic wait_done(input bit clr_on_done);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (done) begin
                got = 1;
                if (clr_on_done) irq_clr = 1'b1;
            end
        end
        check("done_seen", got, 1);
        tick();
        irq_clr = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_rvalid();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (bus.r_valid) got = 1;
            else tick();
        end
        check("rvalid_seen", got, 1);
    endtask

    task automatic check_frame(input int span);
        check("wr_count", wr_din.size(), 16);
        for (int i = 0; i < 16 && i < wr_din.size(); i++)
            check("wr_din", wr_din[i], 32'(i + 1));
        check("wr_addr_bad", wr_bad_addr, 0);
        if (span >= 0) check("wr_span", last_wr - first_wr, span);
        check("rd_after_wr", first_rd - last_wr, 1);
        check("rd_count", rd_addr.size(), 3);
        if (rd_addr.size() == 3) begin
            check("rd_addr0", rd_addr[0], 14'h088);
            check("rd_addr1", rd_addr[1], 14'h089);
            check("rd_addr2", rd_addr[2], 14'h08A);
        end
        check("res_count", res.size(), 3);
        if (res.size() == 3) begin
            check("res0", res[0], 16'h0010);
            check("res1", res[1], 16'h000F);
            check("res2", res[2], 16'h000E);
        end
        check("done_cnt", done_cnt, 1);
        check("idle_bus_zero", idle_bad, 0);
        check("busy_after", busy, 0);
    endtask

    task automatic run_frame(input bit clr_on_done);
        clear_log();
        bus.r_ready = 1'b1;
        pulse_start();
        feed(1, 16, 1'b0);
        wait_done(clr_on_done);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        irq_clr     = 1'b0;
        bus.s_data  = 16'h0;
        bus.s_valid = 1'b0;
        bus.r_ready = 1'b0;
        clear_log();

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start       = 1'($urandom);
            irq_clr     = 1'($urandom);
            bus.s_data  = 16'($urandom);
            bus.s_valid = 1'($urandom);
            bus.r_ready = 1'($urandom);
            tick();
            check("rst_outputs", {bus.per_en, bus.per_we, bus.per_addr, bus.per_din, bus.s_ready,
                                  bus.r_valid, busy, done, irq}, 0);
            check("rst_rdata", bus.r_data, 0);
        end
        start = 1'b0; irq_clr = 1'b0; bus.s_valid = 1'b0; bus.r_ready = 1'b0; bus.s_data = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_sready", bus.s_ready, 0);

        // Full frame, streaming at full rate
        clear_log();
        bus.r_ready = 1'b1;
        pulse_start();
        check("busy_after_start", busy, 1);
        check("sready_after_start", bus.s_ready, 1);
        feed(1, 16, 1'b0);
        wait_done(1'b0);
        check_frame(15);

        // Sample gaps and result backpressure
        clear_log();
        bus.r_ready = 1'b0;
        pulse_start();
        feed(1, 16, 1'b1);
        wait_rvalid();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rvalid_held", bus.r_valid, 1);
            check("bp_rdata_held", bus.r_data, 16'h0010);
        end
        check("bp_no_extra_read", rd_addr.size(), 1);
        bus.r_ready = 1'b1;
        wait_done(1'b0);
        check_frame(30);

        // start while busy is ignored
        clear_log();
        bus.r_ready = 1'b1;
        pulse_start();
        feed(1, 8, 1'b0);
        pulse_start();
        feed(9, 16, 1'b0);
        bus.r_ready = 1'b0;
        wait_rvalid();
        pulse_start();
        bus.r_ready = 1'b1;
        wait_done(1'b0);
        repeat (4) tick();
        check_frame(-1);

        // Reset in the middle of loading
        clear_log();
        bus.r_ready = 1'b1;
        pulse_start();
        feed(1, 7, 1'b0);
        check("pre_rst_en", bus.per_en, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_en", bus.per_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sready", bus.s_ready, 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(1'b0);
        check_frame(15);

        // Interrupt behaviour
`ifdef FFT_BUS_LOADER_IRQ_EN
        check("irq_set", irq, 1);
        repeat (3) tick();
        check("irq_hold", irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_cleared", irq, 0);
        run_frame(1'b1);
        check("irq_set_wins", irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_cleared2", irq, 0);
`else
        check("irq_off", irq, 0);
        run_frame(1'b1);
        check("irq_off_clr", irq, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
